// File: rtl/layer_stream_source.sv
// Ping-pong buffered vector source feeding a layer's valid/ready input, one element per handshake.
// Optional LAYER_SRC_VEC_COUNT_EN adds a 32-bit count of vectors released downstream.
module layer_stream_source #(
    parameter int unsigned T  = 16,
    parameter int unsigned M  = 16,
    parameter int unsigned AW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [T-1:0]  wr_data,
    input  logic          wr_commit,
    output logic          wr_ready,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [T-1:0]  data_out,
    output logic          m_last
`ifdef LAYER_SRC_VEC_COUNT_EN
   ,output logic [31:0]   vec_count
`endif
);

    // State encodes the number of committed banks awaiting transmission.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        BOTH  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          fill_bank_q, fill_bank_d;
    logic          tx_bank_q, tx_bank_d;
    logic [AW-1:0] idx_q, idx_d;

    logic [T-1:0]  mem [0:1][0:M-1];

    logic          commit_ok;
    logic          xfer;
    logic          release_c;

    assign wr_ready  = (state_q != BOTH);
    assign m_valid   = (state_q != EMPTY);
    assign commit_ok = wr_commit && wr_ready;
    assign xfer      = m_valid && m_ready;
    assign release_c = xfer && (idx_q == AW'(M - 1));
    assign data_out  = m_valid ? mem[tx_bank_q][idx_q] : '0;
    assign m_last    = m_valid && (idx_q == AW'(M - 1));

    // Buffer storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ready && (32'(wr_addr) < M)) begin
            mem[fill_bank_q][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            fill_bank_q <= 1'b0;
            tx_bank_q   <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            fill_bank_q <= fill_bank_d;
            tx_bank_q   <= tx_bank_d;
            idx_q       <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_bank_d = fill_bank_q;
        tx_bank_d   = tx_bank_q;
        idx_d       = idx_q;

        if (commit_ok) begin
            fill_bank_d = ~fill_bank_q;
        end

        if (xfer) begin
            if (release_c) begin
                idx_d     = '0;
                tx_bank_d = ~tx_bank_q;
            end else begin
                idx_d = idx_q + AW'(1);
            end
        end

        // Commit and release together leave the occupancy unchanged.
        unique case (state_q)
            EMPTY: if (commit_ok) state_d = ONE;
            ONE: begin
                if (commit_ok && !release_c) state_d = BOTH;
                else if (!commit_ok && release_c) state_d = EMPTY;
            end
            BOTH:  if (release_c) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

`ifdef LAYER_SRC_VEC_COUNT_EN
    logic [31:0] vec_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec_count_q <= '0;
        end else if (release_c) begin
            vec_count_q <= vec_count_q + 32'd1;
        end
    end

    assign vec_count = vec_count_q;
`endif

endmodule

// File: tb/tb_layer_stream_source.sv
// Scoreboard bench for layer_stream_source: expectations queued at commit, monitor pops on each transfer.
module tb_layer_stream_source;

    localparam int unsigned T  = 16;
    localparam int unsigned M  = 16;
    localparam int unsigned AW = $clog2(M);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [T-1:0]  wr_data;
    logic          wr_commit;
    logic          wr_ready;
    logic          m_valid;
    logic          m_ready;
    logic [T-1:0]  data_out;
    logic          m_last;
`ifdef LAYER_SRC_VEC_COUNT_EN
    logic [31:0]   vec_count;
`endif

    layer_stream_source #(.T(T), .M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_commit (wr_commit),
        .wr_ready  (wr_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .data_out  (data_out),
        .m_last    (m_last)
`ifdef LAYER_SRC_VEC_COUNT_EN
       ,.vec_count (vec_count)
`endif
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [T:0]   exp_q [$];
    logic [T-1:0] vbuf [M];
    bit           stall_prev = 1'b0;
    logic [T-1:0] stall_data;
    bit           rnd_done;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pop on every transfer, enforce hold-while-stalled and zeroed idle outputs.
    always @(negedge clk) begin
        logic [T:0] e;
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check(m_valid == 1'b1, "stall_valid_hold", 32'(m_valid), 32'd1);
                check(data_out == stall_data, "stall_data_hold", 32'(data_out), 32'(stall_data));
            end
            if (!m_valid) begin
                check(data_out == '0 && !m_last, "idle_zero", {15'd0, m_last, data_out}, 32'd0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_xfer", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check(data_out == e[T-1:0], "xfer_data", 32'(data_out), 32'(e[T-1:0]));
                    check(m_last == e[T], "xfer_last", 32'(m_last), 32'(e[T]));
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_data = data_out;
        end
    end

    task automatic wr(input int a, input logic [T-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic fill_vec();
        for (int i = 0; i < int'(M); i++) wr(i, vbuf[i]);
    endtask

    task automatic push_vec();
        for (int i = 0; i < int'(M); i++) exp_q.push_back({(i == int'(M) - 1), vbuf[i]});
    endtask

    task automatic commit_push();
        push_vec();
        wr_commit = 1'b1;
        @(posedge clk); #1;
        wr_commit = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!wr_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!wr_ready) check(1'b0, name, 32'(wr_ready), 32'd1);
    endtask

    task automatic drain(input int exp_cycles, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check(exp_q.size() == 0, {name, "_empty"}, 32'(exp_q.size()), 32'd0);
        if (exp_cycles > 0) check(n == exp_cycles, {name, "_cycles"}, 32'(n), 32'(exp_cycles));
        check(!m_valid, {name, "_idle"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_commit = 1'b0; m_ready = 1'b0;
        #12;
        check(!m_valid, "rst_valid", 32'(m_valid), 32'd0);
        check(data_out == '0, "rst_data", 32'(data_out), 32'd0);
        check(!m_last, "rst_last", 32'(m_last), 32'd0);
        check(wr_ready, "rst_wr_ready", 32'(wr_ready), 32'd1);
`ifdef LAYER_SRC_VEC_COUNT_EN
        check(vec_count == 32'd0, "rst_vec_count", vec_count, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Single vector, continuous ready
        for (int i = 0; i < 16; i++) vbuf[i] = 16'h0000 + T'(i);
        fill_vec();
        m_ready = 1'b1;
        check(!m_valid, "t1_valid_pre", 32'(m_valid), 32'd0);
        commit_push();
        check(m_valid, "t1_valid_post", 32'(m_valid), 32'd1);
        check(wr_ready, "t1_wr_ready", 32'(wr_ready), 32'd1);
        drain(16, "t1");
        check(wr_ready, "t1_wr_ready_end", 32'(wr_ready), 32'd1);

        // Two banks full, overflow attempts ignored, then bubble-free stream
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) vbuf[i] = 16'h1000 + T'(i);
        fill_vec();
        commit_push();
        check(wr_ready, "t2_wr_ready_one", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 16; i++) vbuf[i] = 16'h2000 + T'(i);
        fill_vec();
        commit_push();
        check(!wr_ready, "t2_wr_ready_full", 32'(wr_ready), 32'd0);
        wr(3, 16'hDEAD);
        wr_commit = 1'b1;
        @(posedge clk); #1;
        wr_commit = 1'b0;
        check(!wr_ready, "t2_wr_ready_after_ign", 32'(wr_ready), 32'd0);
        check(data_out == 16'h1000, "t2_head", 32'(data_out), 32'h1000);
        m_ready = 1'b1;
        drain(32, "t2");

        // Random ready, 100 pseudo-random vectors
        rnd_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 100; v++) begin
                    for (int i = 0; i < 16; i++) vbuf[i] = T'($urandom);
                    wait_ready("t3_wr_ready_timeout");
                    fill_vec();
                    commit_push();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        drain(-1, "t3");

        // Commit coinciding with release while one bank is full
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) vbuf[i] = 16'h3000 + T'(i);
        fill_vec();
        commit_push();
        for (int i = 0; i < 16; i++) vbuf[i] = 16'h4000 + T'(i);
        fill_vec();
        m_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        commit_push();
        check(m_valid, "t4_valid", 32'(m_valid), 32'd1);
        check(wr_ready, "t4_wr_ready", 32'(wr_ready), 32'd1);
        check(data_out == 16'h4000, "t4_next_head", 32'(data_out), 32'h4000);
        drain(16, "t4");

        // Asynchronous reset mid-vector
        for (int i = 0; i < 16; i++) vbuf[i] = 16'h5000 + T'(i);
        fill_vec();
        commit_push();
        repeat (7) @(posedge clk);
        #2;
        check(data_out == 16'h5007, "t5_elem7", 32'(data_out), 32'h5007);
`ifdef LAYER_SRC_VEC_COUNT_EN
        check(vec_count == 32'd105, "t5_vec_count_pre", vec_count, 32'd105);
`endif
        reset = 1'b0;
        #1;
        check(!m_valid, "t5_valid", 32'(m_valid), 32'd0);
        check(data_out == '0, "t5_data", 32'(data_out), 32'd0);
        check(wr_ready, "t5_wr_ready", 32'(wr_ready), 32'd1);
`ifdef LAYER_SRC_VEC_COUNT_EN
        check(vec_count == 32'd0, "t5_vec_count_rst", vec_count, 32'd0);
`endif
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check(!m_valid, "t5_no_output", 32'(m_valid), 32'd0);
        end

        // Three vectors after reset
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 16; i++) vbuf[i] = 16'h6000 + T'(v * 16 + i);
            wait_ready("t6_wr_ready_timeout");
            fill_vec();
            commit_push();
        end
        drain(-1, "t6");
`ifdef LAYER_SRC_VEC_COUNT_EN
        check(vec_count == 32'd3, "t6_vec_count", vec_count, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
